// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants, flag indices and sequencer state encoding
package alu_pkg;

    // Flag nibble bit positions: [3]=N [2]=Z [1]=C [0]=V
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - NZCV flag update shared by the ALU shift and add units
//
// Ports:
//   result   in  DATA_W  value the flags are derived from
//   carry    in  1       carry produced by the operation
//   flag_in  in  4       incoming flags, [3]=N [2]=Z [1]=C [0]=V
//   s        in  1       1 = update flags from result, 0 = pass flag_in through
//   c_valid  in  1       1 = operation produced a carry, 0 = keep flag_in C
//   new_flag out 4       resulting flags, same bit order as flag_in
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] result,
    input  logic              carry,
    input  logic [3:0]        flag_in,
    input  logic              s,
    input  logic              c_valid,
    output logic [3:0]        new_flag
);

    always_comb begin
        new_flag = flag_in;
        if (s) begin
            new_flag[FLAG_N] = result[DATA_W-1];
            new_flag[FLAG_Z] = (result == '0);
            new_flag[FLAG_C] = c_valid ? carry : flag_in[FLAG_C];
            new_flag[FLAG_V] = flag_in[FLAG_V];
        end
    end

endmodule

// File: rtl/lsl_seq.sv
// rtl/lsl_seq.sv - iterative logical shift left, one bit per clock, with NZCV flags
//
// Ports:
//   clk      in  1       system clock, rising edge
//   rst_n    in  1       synchronous active-low reset
//   start    in  1       request, accepted only in IDLE
//   in1      in  DATA_W  operand, latched on accept
//   in2      in  SHW     unsigned shift amount, latched on accept
//   flag_in  in  4       current flags, latched on accept
//   s        in  1       flag update select, latched on accept
//   busy     out 1       high whenever state != IDLE
//   done     out 1       one-cycle completion pulse
//   result   out DATA_W  shifted value, held until next completion
//   new_flag out 4       output flags, held until next completion
module lsl_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int SHW    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] in1,
    input  logic [SHW-1:0]    in2,
    input  logic [3:0]        flag_in,
    input  logic              s,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        new_flag
);

    seq_state_e        state_q,    state_d;
    logic [DATA_W-1:0] acc_q,      acc_d;
    logic [SHW-1:0]    cnt_q,      cnt_d;
    logic              carry_q,    carry_d;
    logic [3:0]        flag_q,     flag_d;
    logic              s_q,        s_d;
    logic              c_valid_q,  c_valid_d;
    logic [DATA_W-1:0] result_q,   result_d;
    logic [3:0]        new_flag_q, new_flag_d;
    logic              done_q,     done_d;

    logic [3:0]        flag_gen_out;

    alu_flag_gen #(
        .DATA_W (DATA_W)
    ) u_flag_gen (
        .result   (acc_q),
        .carry    (carry_q),
        .flag_in  (flag_q),
        .s        (s_q),
        .c_valid  (c_valid_q),
        .new_flag (flag_gen_out)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        flag_d     = flag_q;
        s_d        = s_q;
        c_valid_d  = c_valid_q;
        result_d   = result_q;
        new_flag_d = new_flag_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d     = in1;
                    cnt_d     = in2;
                    flag_d    = flag_in;
                    s_d       = s;
                    // A zero-length shift shifts nothing out, so C keeps its old value.
                    carry_d   = flag_in[FLAG_C];
                    c_valid_d = (in2 != '0);
                    state_d   = (in2 != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                carry_d = acc_q[DATA_W-1];
                acc_d   = acc_q << 1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                result_d   = acc_q;
                new_flag_d = flag_gen_out;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            flag_q     <= 4'b0;
            s_q        <= 1'b0;
            c_valid_q  <= 1'b0;
            result_q   <= '0;
            new_flag_q <= 4'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            flag_q     <= flag_d;
            s_q        <= s_d;
            c_valid_q  <= c_valid_d;
            result_q   <= result_d;
            new_flag_q <= new_flag_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign result   = result_q;
    assign new_flag = new_flag_q;

endmodule
